entity_line_compositor: RTL and testbench
=========================================

ENTITY_LINE_COMPOSITOR -- requirements
Module: entity_line_compositor

Interface
REQ-001 Parameter NUM_ENT, default 9, number of entity channels (2..16).
REQ-002 Parameter SLOTS, default 4, max entities latched per tile row (1..8).
REQ-003 Parameter TILE_LOG2, default 3, log2 of tile edge in pixels (tile = 8x8 by default).
REQ-004 clk  in  1  single system/pixel clock; all state rises on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 entities  in  14*NUM_ENT  channel n at [14n+13:14n]: [13:10] ID, [9:8] orientation, [7:4] tile row, [3:0] tile column; ID 4'hF = unused.
REQ-007 line_start  in  1  one-cycle pulse; begins a scan for tile row next_row.
REQ-008 next_row  in  4  tile row to scan, sampled only on line_start.
REQ-009 pix_valid  in  1  active-video pixel strobe.
REQ-010 tile_col  in  4  tile column of current pixel, qualified by pix_valid.
REQ-011 sub_x, sub_y  in  TILE_LOG2 each  pixel offset inside tile, qualified by pix_valid.
REQ-012 rom_addr  out  4+2*TILE_LOG2  sprite ROM address {ID, y', x'}, registered.
REQ-013 rom_data  in  1  sprite pixel, valid exactly one cycle after rom_addr changes.
REQ-014 colour  out  1  composited pixel; colour_valid  out  1  qualifies it.
REQ-015 scan_busy  out  1  high while scanning; overflow  out  1  sticky per line.

Function
REQ-016 FSM states IDLE, SCAN, READY; reset enters IDLE.
REQ-017 line_start in any state: clear all slot valids, slot count = 0, overflow = 0, channel index = 0, latch next_row, go SCAN next cycle.
REQ-018 SCAN examines one channel per cycle, index 0 upward; scan_busy high throughout.
REQ-019 Channel matches if ID != 4'hF and tile row == latched row.
REQ-020 Match with count < SLOTS: store {ID, orientation, column} in slot[count], count += 1.
REQ-021 Match with count == SLOTS: channel dropped, overflow set, held until next line_start.
REQ-022 After examining index NUM_ENT-1, go READY; scan takes exactly NUM_ENT cycles.
REQ-023 Slot order equals channel order; lower slot index has priority.
REQ-024 Pixel stage 1 (pix_valid cycle, state READY): select lowest valid slot with column == tile_col; register hit and rom_addr.
REQ-025 Orientation transform before addressing: 00 none; 01 x' = ~sub_x; 10 y' = ~sub_y; 11 both inverted.
REQ-026 No hit: rom_addr holds previous value, hit = 0.
REQ-027 Stage 2 (next cycle): colour <= hit & rom_data; colour_valid <= stage-1 valid; latency pix_valid -> colour_valid = 2 cycles, fully pipelined, one pixel per cycle.
REQ-028 pix_valid in IDLE or SCAN: pixel still propagates with hit forced 0 (colour 0, colour_valid 1 two cycles later).
REQ-029 Transparent sprite pixel (rom_data 0) yields colour 0; no fall-through to lower-priority slots.
REQ-030 entities may change at any time; only the value sampled on the cycle a channel is examined counts.
REQ-031 line_start during SCAN restarts the scan; pipeline stages in flight complete unaffected.

Reset
REQ-032 Reset asserted: state IDLE, all slot valids 0, count 0, index 0, overflow 0, scan_busy 0, rom_addr 0, hit 0, colour 0, colour_valid 0, asynchronously.
REQ-033 Reset asserted mid-scan or mid-pipeline discards all in-flight state; first line_start after release behaves per REQ-017.

Verification
REQ-034 Defaults, ch0 = {ID 2, ori 00, row 3, col 5}, others ID F; line_start row 3; wait 9 cycles; pixel col 5, sub (1,2), rom_data 1 -> rom_addr {2,2,1}, colour 1 two cycles after pix_valid; col 6 -> colour 0.
REQ-035 Orientation: same entity ori 11, sub (1,2) -> rom_addr {2,5,6}; ori 01 -> {2,2,6}.
REQ-036 Overflow: 6 channels on row 3, SLOTS 4 -> slots hold ch0..3, overflow 1 after scan; next line_start clears overflow to 0.
REQ-037 Priority: ch1 and ch4 both col 5, ch1 sprite pixel 0, ch4 pixel 1 -> colour 0.
REQ-038 Restart/reset: line_start at scan cycle 4 -> scan_busy for 9 further cycles; reset asserted mid-scan -> all outputs 0 same cycle, state IDLE.
REQ-039 Back-to-back pix_valid for 16 cycles in READY -> 16 consecutive colour_valid cycles, order preserved.

Source files
------------

// File: rtl/entity_line_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : entity_line_compositor
//  Purpose  : Latches up to SLOTS entities that sit on one tile row, then
//             composites a 1-bit sprite pixel per active-video pixel through
//             a two-stage pipeline (slot select + ROM address, then colour).
//  Revision : 1.0 - initial release
// ============================================================================
module entity_line_compositor #(
  parameter int NUM_ENT   = 9,
  parameter int SLOTS     = 4,
  parameter int TILE_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [14*NUM_ENT-1:0]    entities,
  input  logic                     line_start,
  input  logic [3:0]               next_row,
  input  logic                     pix_valid,
  input  logic [3:0]               tile_col,
  input  logic [TILE_LOG2-1:0]     sub_x,
  input  logic [TILE_LOG2-1:0]     sub_y,
  output logic [4+2*TILE_LOG2-1:0] rom_addr,
  input  logic                     rom_data,
  output logic                     colour,
  output logic                     colour_valid,
  output logic                     scan_busy,
  output logic                     overflow
);

  localparam logic [3:0] c_LAST_IDX  = 4'(NUM_ENT - 1);
  localparam logic [3:0] c_SLOTS     = 4'(SLOTS);
  localparam logic [3:0] c_ID_UNUSED = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Scan context
  logic [3:0]       r_row;
  logic [3:0]       r_idx;
  logic [3:0]       r_count;
  logic             r_overflow;

  // Slot table, lower index = earlier channel = higher priority
  logic [SLOTS-1:0] r_slot_valid;
  logic [3:0]       r_slot_id  [SLOTS];
  logic [1:0]       r_slot_ori [SLOTS];
  logic [3:0]       r_slot_col [SLOTS];

  // Channel currently under examination
  logic [13:0]      w_ent;
  logic             w_match;

  // Pixel stage 1 selection
  logic             w_hit;
  logic [3:0]       w_sel_id;
  logic [1:0]       w_sel_ori;
  logic [TILE_LOG2-1:0] w_x;
  logic [TILE_LOG2-1:0] w_y;

  // Pipeline registers
  logic [4+2*TILE_LOG2-1:0] r_rom_addr;
  logic             r_hit;
  logic             r_v1;
  logic             r_colour;
  logic             r_colour_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: line_start always (re)starts a scan; a scan lasts NUM_ENT cycles
  always_comb begin
    w_state_next = r_state;
    if (line_start) begin
      w_state_next = S_SCAN;
    end else begin
      case (r_state)
        S_SCAN:  if (r_idx == c_LAST_IDX) w_state_next = S_READY;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Pick the channel addressed by the scan index and test it against the row
  always_comb begin
    w_ent = 14'h0;
    for (int n = 0; n < NUM_ENT; n++) begin
      if (r_idx == 4'(n)) w_ent = entities[14*n +: 14];
    end
    w_match = (w_ent[13:10] != c_ID_UNUSED) && (w_ent[7:4] == r_row);
  end

  // Scan datapath: fill slots in channel order, flag channels that do not fit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row        <= '0;
      r_idx        <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_slot_valid <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_slot_id[s]  <= '0;
        r_slot_ori[s] <= '0;
        r_slot_col[s] <= '0;
      end
    end else if (line_start) begin
      r_row        <= next_row;
      r_idx        <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_slot_valid <= '0;
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + 4'd1;
      if (w_match) begin
        if (r_count < c_SLOTS) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (r_count == 4'(s)) begin
              r_slot_valid[s] <= 1'b1;
              r_slot_id[s]    <= w_ent[13:10];
              r_slot_ori[s]   <= w_ent[9:8];
              r_slot_col[s]   <= w_ent[3:0];
            end
          end
          r_count <= r_count + 4'd1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Lowest valid slot on this column wins; only a completed scan may hit
  always_comb begin
    w_hit     = 1'b0;
    w_sel_id  = '0;
    w_sel_ori = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (r_slot_valid[s] && (r_slot_col[s] == tile_col)) begin
        w_hit     = 1'b1;
        w_sel_id  = r_slot_id[s];
        w_sel_ori = r_slot_ori[s];
      end
    end
    if (r_state != S_READY) w_hit = 1'b0;
    w_x = w_sel_ori[0] ? ~sub_x : sub_x;
    w_y = w_sel_ori[1] ? ~sub_y : sub_y;
  end

  // Stage 1: register hit and sprite ROM address (address holds on a miss)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_hit      <= 1'b0;
      r_v1       <= 1'b0;
    end else begin
      r_v1  <= pix_valid;
      r_hit <= pix_valid & w_hit;
      if (pix_valid && w_hit) r_rom_addr <= {w_sel_id, w_y, w_x};
    end
  end

  // Stage 2: gate the returned sprite pixel with the hit flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_colour       <= 1'b0;
      r_colour_valid <= 1'b0;
    end else begin
      r_colour       <= r_hit & rom_data;
      r_colour_valid <= r_v1;
    end
  end

  assign rom_addr     = r_rom_addr;
  assign colour       = r_colour;
  assign colour_valid = r_colour_valid;
  assign scan_busy    = (r_state == S_SCAN);
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_entity_line_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entity_line_compositor
//  Purpose  : Self-checking bench; behavioural line/slot model plus directed
//             literal scenarios and a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_entity_line_compositor;

  localparam int NUM_ENT = 9;
  localparam int SLOTS   = 4;
  localparam int TL      = 3;
  localparam int AW      = 4 + 2*TL;
  localparam int TMAX    = (1 << TL) - 1;

  logic                  clk;
  logic                  reset;
  logic [14*NUM_ENT-1:0] entities;
  logic                  line_start;
  logic [3:0]            next_row;
  logic                  pix_valid;
  logic [3:0]            tile_col;
  logic [TL-1:0]         sub_x;
  logic [TL-1:0]         sub_y;
  logic [AW-1:0]         rom_addr;
  logic                  rom_data;
  logic                  colour;
  logic                  colour_valid;
  logic                  scan_busy;
  logic                  overflow;

  bit rom_mem [0:(1<<AW)-1];
  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entity_line_compositor #(
    .NUM_ENT  (NUM_ENT),
    .SLOTS    (SLOTS),
    .TILE_LOG2(TL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entities    (entities),
    .line_start  (line_start),
    .next_row    (next_row),
    .pix_valid   (pix_valid),
    .tile_col    (tile_col),
    .sub_x       (sub_x),
    .sub_y       (sub_y),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .colour      (colour),
    .colour_valid(colour_valid),
    .scan_busy   (scan_busy),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  q_id[$];
  int  q_ori[$];
  int  q_col[$];
  int  m_row, m_pos, m_addr;
  bit  m_scan, m_ready, m_ovf;
  bit  p1_v, p1_c, o_v, o_c;

  task automatic model_reset();
    q_id.delete(); q_ori.delete(); q_col.delete();
    m_row = 0; m_pos = 0; m_addr = 0;
    m_scan = 0; m_ready = 0; m_ovf = 0;
    p1_v = 0; p1_c = 0; o_v = 0; o_c = 0;
  endtask

  task automatic model_step();
    int sx, sy;
    bit found;
    logic [13:0] e;
    o_v  = p1_v;
    o_c  = p1_c;
    p1_v = pix_valid;
    p1_c = 0;
    if (pix_valid && m_ready) begin
      found = 0;
      for (int k = 0; k < q_col.size(); k++) begin
        if (!found && q_col[k] == int'(tile_col)) begin
          found  = 1;
          sx     = ((q_ori[k] & 1) != 0) ? TMAX - int'(sub_x) : int'(sub_x);
          sy     = ((q_ori[k] & 2) != 0) ? TMAX - int'(sub_y) : int'(sub_y);
          m_addr = q_id[k] * (1 << (2*TL)) + sy * (1 << TL) + sx;
          p1_c   = rom_mem[m_addr];
        end
      end
    end
    if (line_start) begin
      q_id.delete(); q_ori.delete(); q_col.delete();
      m_row = int'(next_row); m_pos = 0;
      m_scan = 1; m_ready = 0; m_ovf = 0;
    end else if (m_scan) begin
      e = entities[14*m_pos +: 14];
      if (e[13:10] != 4'hF && int'(e[7:4]) == m_row) begin
        if (q_id.size() < SLOTS) begin
          q_id.push_back(int'(e[13:10]));
          q_ori.push_back(int'(e[9:8]));
          q_col.push_back(int'(e[3:0]));
        end else begin
          m_ovf = 1;
        end
      end
      m_pos++;
      if (m_pos == NUM_ENT) begin
        m_scan  = 0;
        m_ready = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("cmp_colour_valid", int'(colour_valid), int'(o_v));
        chk("cmp_colour",       int'(colour),       int'(o_c));
        chk("cmp_scan_busy",    int'(scan_busy),    int'(m_scan));
        chk("cmp_overflow",     int'(overflow),     int'(m_ovf));
        chk("cmp_rom_addr",     int'(rom_addr),     m_addr);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic set_ent(input int n, input int id, input int ori, input int row, input int col);
    entities[14*n +: 14] = {4'(id), 2'(ori), 4'(row), 4'(col)};
  endtask

  task automatic line(input int row);
    line_start = 1'b1;
    next_row   = 4'(row);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_scan(input string nm, input int exp);
    int n = 0;
    while (scan_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp);
  endtask

  task automatic pix_check(input string nm, input int col, input int sx, input int sy,
                           input int exp_addr, input int exp_colour);
    pix_valid = 1'b1;
    tile_col  = 4'(col);
    sub_x     = TL'(sx);
    sub_y     = TL'(sy);
    @(negedge clk);
    pix_valid = 1'b0;
    chk({nm, "_addr"}, int'(rom_addr), exp_addr);
    @(negedge clk);
    chk({nm, "_cv"}, int'(colour_valid), 1);
    chk({nm, "_colour"}, int'(colour), exp_colour);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cv_cnt;
    reset      = 1'b1;
    line_start = 1'b0;
    next_row   = '0;
    pix_valid  = 1'b0;
    tile_col   = '0;
    sub_x      = '0;
    sub_y      = '0;
    entities   = '1;
    for (int i = 0; i < (1<<AW); i++) rom_mem[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_colour",    int'(colour), 0);
    chk("rst_cv",        int'(colour_valid), 0);
    chk("rst_busy",      int'(scan_busy), 0);
    chk("rst_overflow",  int'(overflow), 0);
    chk("rst_rom_addr",  int'(rom_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic hit / miss
    set_ent(0, 2, 0, 3, 5);
    rom_mem[145] = 1'b1;
    rom_mem[174] = 1'b1;
    line(3);
    wait_scan("scan_len", 9);
    pix_check("basic_hit", 5, 1, 2, 145, 1);
    pix_check("basic_miss", 6, 1, 2, 145, 0);

    // Orientation
    set_ent(0, 2, 3, 3, 5);
    line(3);
    wait_scan("scan_len_o11", 9);
    pix_check("ori11", 5, 1, 2, 174, 1);
    set_ent(0, 2, 1, 3, 5);
    line(3);
    wait_scan("scan_len_o01", 9);
    pix_check("ori01", 5, 1, 2, 150, 0);

    // Overflow
    entities = '1;
    for (int n = 0; n < 6; n++) set_ent(n, n + 1, 0, 3, n);
    rom_mem[256] = 1'b1;
    rom_mem[320] = 1'b1;
    line(3);
    wait_scan("scan_len_ovf", 9);
    chk("ovf_set", int'(overflow), 1);
    pix_check("ovf_slot3", 3, 0, 0, 256, 1);
    pix_check("ovf_dropped", 4, 0, 0, 256, 0);
    line(3);
    chk("ovf_cleared", int'(overflow), 0);
    wait_scan("scan_len_ovf2", 9);

    // Priority with transparent pixel
    entities = '1;
    set_ent(1, 7, 0, 3, 5);
    set_ent(4, 8, 0, 3, 5);
    rom_mem[448] = 1'b0;
    rom_mem[512] = 1'b1;
    line(3);
    wait_scan("scan_len_pri", 9);
    pix_check("priority", 5, 0, 0, 448, 0);

    // Restart mid-scan
    line(3);
    repeat (3) @(negedge clk);
    line(3);
    wait_scan("restart_len", 9);

    // Asynchronous reset mid-scan
    line(3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_colour",   int'(colour), 0);
    chk("arst_cv",       int'(colour_valid), 0);
    chk("arst_busy",     int'(scan_busy), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    pix_check("idle_pix", 5, 0, 0, 0, 0);
    line(3);
    wait_scan("scan_after_rst", 9);

    // Back-to-back burst of 16 pixels
    cv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (colour_valid) cv_cnt++;
      pix_valid = (i < 16);
      tile_col  = 4'($urandom_range(5, 6));
      sub_x     = TL'($urandom_range(0, TMAX));
      sub_y     = TL'($urandom_range(0, TMAX));
      @(negedge clk);
    end
    chk("burst_cv_count", cv_cnt, 16);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized phase
    for (int i = 0; i < (1<<AW); i++) rom_mem[i] = bit'($urandom_range(0, 1));
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < NUM_ENT; n++)
        set_ent(n, ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 14),
                $urandom_range(0, 3), $urandom_range(2, 3), $urandom_range(0, 7));
      line_start = ($urandom_range(0, 19) == 0);
      next_row   = 4'($urandom_range(2, 3));
      pix_valid  = ($urandom_range(0, 3) != 0);
      tile_col   = 4'($urandom_range(0, 7));
      sub_x      = TL'($urandom_range(0, TMAX));
      sub_y      = TL'($urandom_range(0, TMAX));
      @(negedge clk);
    end
    line_start = 1'b0;
    pix_valid  = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
